// File: rtl/uart_rx_gen.sv
// uart_rx_gen - oversampled UART receiver with parity/framing checks and a
// one-word output buffer with overrun detection.
//
// Parameters:
//   DATA_W    - data bits per frame (5..9)
//   OSR       - b_tick pulses per bit period (even, >= 4)
//   STOP_BITS - stop bits checked per frame (1 or 2)
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   b_tick     - oversampling tick, one-cycle pulse
//   rx         - asynchronous serial line, idle high
//   parity_en  - a parity bit follows the data bits
//   parity_odd - 1 = odd parity, 0 = even parity
//   dout       - received word, LSB first on the line
//   dout_valid - dout holds an unconsumed word
//   dout_ready - consumer accepts the word
//   parity_err - parity mismatch on the word in dout
//   frame_err  - a stop bit of the word in dout sampled low
//   overrun    - sticky: a frame was dropped while dout was full
//   busy       - receiver is not idle
module uart_rx_gen #(
  parameter int DATA_W    = 8,
  parameter int OSR       = 16,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              b_tick,
  input  logic              rx,
  input  logic              parity_en,
  input  logic              parity_odd,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OSR - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     tick_cnt, tick_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic              stop_cnt, stop_n;
  logic [DATA_W-1:0] shift_reg, shift_n;
  logic              perr_r, perr_n;
  logic              ferr_r, ferr_n;
  logic              complete;
  logic              rx_meta, rx_s;

  // Two-flop synchronizer; resets to the idle line level so a reset never
  // looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= '0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      stop_cnt  <= stop_n;
      shift_reg <= shift_n;
      perr_r    <= perr_n;
      ferr_r    <= ferr_n;
    end
  end

  // Next-state logic. Every counting state advances only on b_tick and
  // restarts its tick counter at each sample, so it never wraps.
  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_cnt;
    stop_n   = stop_cnt;
    shift_n  = shift_reg;
    perr_n   = perr_r;
    ferr_n   = ferr_r;
    complete = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          tick_n  = '0;
        end
      end
      START: begin
        if (b_tick) begin
          if (tick_cnt == HALF_LAST) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              tick_n  = '0;
              bit_n   = '0;
              perr_n  = 1'b0;
              ferr_n  = 1'b0;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (b_tick) begin
          if (tick_cnt == BIT_LAST) begin
            shift_n = {rx_s, shift_reg[DATA_W-1:1]};
            tick_n  = '0;
            bit_n   = bit_cnt + 1'b1;
            if (bit_cnt == DATA_LAST) begin
              stop_n  = 1'b0;
              state_n = PARITY;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        // parity_en is consulted only here; with parity off we pass straight
        // through, still counting a tick that lands in this cycle so the
        // stop-bit timing is unaffected.
        if (!parity_en) begin
          state_n = STOP;
          tick_n  = b_tick ? TW'(1) : '0;
        end else if (b_tick) begin
          if (tick_cnt == BIT_LAST) begin
            perr_n  = ((^shift_reg) ^ rx_s) != parity_odd;
            tick_n  = '0;
            state_n = STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (b_tick) begin
          if (tick_cnt == BIT_LAST) begin
            if (!rx_s) begin
              ferr_n = 1'b1;
            end
            tick_n = '0;
            if (stop_cnt == STOP_LAST) begin
              state_n  = IDLE;
              complete = 1'b1;
            end else begin
              stop_n = stop_cnt + 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output buffer. A completed frame loads only when the buffer is empty or
  // being drained in the same cycle; otherwise it is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (complete && (!dout_valid || dout_ready)) begin
      dout       <= shift_reg;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      dout_valid <= 1'b1;
    end else if (complete) begin
      overrun <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_gen.sv
// tb_uart_rx_gen - self-checking bench for uart_rx_gen.
// Instance dut uses one stop bit, dut2 uses two. b_tick pulses every other
// clock, so one bit period on the line is 32 clocks.
module tb_uart_rx_gen;

  localparam int BIT_CLKS  = 32;
  localparam int IDLE_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_div = 1'b0;
  logic       b_tick;
  logic       rx, rx2;
  logic       parity_en, parity_odd;
  logic [7:0] dout, dout2;
  logic       dout_valid, dout_valid2;
  logic       dout_ready, dout_ready2;
  logic       parity_err, parity_err2;
  logic       frame_err, frame_err2;
  logic       overrun, overrun2;
  logic       busy, busy2;

  int tests_run = 0;
  int tests_failed = 0;
  logic done_seen;
  logic rise_seen;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop_lvl;
    logic [7:0] exp_dout;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  uart_rx_gen #(.DATA_W(8), .OSR(16), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx),
    .parity_en(parity_en), .parity_odd(parity_odd),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  uart_rx_gen #(.DATA_W(8), .OSR(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx2),
    .parity_en(parity_en), .parity_odd(parity_odd),
    .dout(dout2), .dout_valid(dout_valid2), .dout_ready(dout_ready2),
    .parity_err(parity_err2), .frame_err(frame_err2),
    .overrun(overrun2), .busy(busy2)
  );

  // Clock and the every-other-cycle oversampling tick.
  always #5 clk = ~clk;

  always @(posedge clk) tick_div <= ~tick_div;
  assign b_tick = tick_div;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx2 = v;
    else     rx  = v;
  endtask

  task automatic hold_bit(input bit sel, input logic v);
    drive(sel, v);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Sends one frame on the selected line. The final stop level is held until
  // the receiver drops busy (bounded), recording whether dout_valid rose on
  // exactly that edge; then the line idles high.
  task automatic applyStimulus(input bit sel, input logic [7:0] data,
                               input logic pen, input logic pbit,
                               input int nstop, input logic last_stop);
    logic prev_v;
    logic got;
    hold_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(sel, data[i]);
    if (pen) hold_bit(sel, pbit);
    for (int s = 0; s < nstop - 1; s++) hold_bit(sel, 1'b1);
    drive(sel, last_stop);
    got = 1'b0;
    rise_seen = 1'b0;
    prev_v = sel ? dout_valid2 : dout_valid;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (!(sel ? busy2 : busy)) begin
        got = 1'b1;
        rise_seen = !prev_v && (sel ? dout_valid2 : dout_valid);
      end else begin
        prev_v = sel ? dout_valid2 : dout_valid;
      end
    end
    done_seen = got;
    drive(sel, 1'b1);
    repeat (IDLE_CLKS) @(negedge clk);
  endtask

  task automatic consume(input bit sel);
    if (sel) dout_ready2 = 1'b1;
    else     dout_ready  = 1'b1;
    @(negedge clk);
    dout_ready  = 1'b0;
    dout_ready2 = 1'b0;
  endtask

  initial begin
    int cnt;
    logic got;

    // data, pen, podd, pbit, stop, exp_dout, exp_perr, exp_ferr
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};

    rst = 1'b1;
    rx = 1'b1;
    rx2 = 1'b1;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    dout_ready = 1'b0;
    dout_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset dout", 32'(dout), 32'h0);
    checkOutput("reset dout_valid", 32'(dout_valid), 32'h0);
    checkOutput("reset parity_err", 32'(parity_err), 32'h0);
    checkOutput("reset frame_err", 32'(frame_err), 32'h0);
    checkOutput("reset overrun", 32'(overrun), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (IDLE_CLKS) @(negedge clk);

    // Table-driven frames on the single-stop receiver.
    for (int i = 0; i < 7; i++) begin
      parity_en  = vecs[i].pen;
      parity_odd = vecs[i].podd;
      applyStimulus(1'b0, vecs[i].data, vecs[i].pen, vecs[i].pbit, 1,
                    vecs[i].stop_lvl);
      checkOutput($sformatf("vec%0d done", i), 32'(done_seen), 32'h1);
      checkOutput($sformatf("vec%0d valid_rise", i), 32'(rise_seen), 32'h1);
      checkOutput($sformatf("vec%0d dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      checkOutput($sformatf("vec%0d parity_err", i), 32'(parity_err),
                  32'(vecs[i].exp_perr));
      checkOutput($sformatf("vec%0d frame_err", i), 32'(frame_err),
                  32'(vecs[i].exp_ferr));
      checkOutput($sformatf("vec%0d overrun", i), 32'(overrun), 32'h0);
      consume(1'b0);
      checkOutput($sformatf("vec%0d valid_after_take", i), 32'(dout_valid), 32'h0);
    end
    parity_en = 1'b0;
    parity_odd = 1'b0;

    // False start: 4 ticks low, then high.
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    checkOutput("false_start busy", 32'(busy), 32'h1);
    got = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      cnt++;
      if (!busy) got = 1'b1;
    end
    checkOutput("false_start idle", 32'(got), 32'h1);
    checkOutput("false_start timing", 32'(cnt >= 6 && cnt <= 14), 32'h1);
    checkOutput("false_start no_valid", 32'(dout_valid), 32'h0);
    repeat (IDLE_CLKS) @(negedge clk);

    // Overrun: two frames without consuming.
    applyStimulus(1'b0, 8'h11, 1'b0, 1'b0, 1, 1'b1);
    checkOutput("ovr first dout", 32'(dout), 32'h11);
    checkOutput("ovr first overrun", 32'(overrun), 32'h0);
    applyStimulus(1'b0, 8'h22, 1'b0, 1'b0, 1, 1'b1);
    checkOutput("ovr second done", 32'(done_seen), 32'h1);
    checkOutput("ovr kept dout", 32'(dout), 32'h11);
    checkOutput("ovr valid", 32'(dout_valid), 32'h1);
    checkOutput("ovr overrun", 32'(overrun), 32'h1);
    consume(1'b0);
    checkOutput("ovr take valid", 32'(dout_valid), 32'h0);
    checkOutput("ovr take overrun", 32'(overrun), 32'h0);

    // Reset in the middle of data bit 4 with a word still buffered.
    applyStimulus(1'b0, 8'h99, 1'b0, 1'b0, 1, 1'b1);
    checkOutput("pre_rst valid", 32'(dout_valid), 32'h1);
    hold_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'b0, 1'b0);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    checkOutput("pre_rst busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst busy", 32'(busy), 32'h0);
    checkOutput("mid_rst valid", 32'(dout_valid), 32'h0);
    checkOutput("mid_rst dout", 32'(dout), 32'h0);
    rst = 1'b0;
    repeat (IDLE_CLKS) @(negedge clk);
    applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1, 1'b1);
    checkOutput("post_rst done", 32'(done_seen), 32'h1);
    checkOutput("post_rst dout", 32'(dout), 32'h3C);
    checkOutput("post_rst valid", 32'(dout_valid), 32'h1);
    checkOutput("post_rst frame_err", 32'(frame_err), 32'h0);
    consume(1'b0);

    // Two stop bits: second stop low, then a clean frame.
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 2, 1'b0);
    checkOutput("stop2 done", 32'(done_seen), 32'h1);
    checkOutput("stop2 valid_rise", 32'(rise_seen), 32'h1);
    checkOutput("stop2 dout", 32'(dout2), 32'h5A);
    checkOutput("stop2 frame_err", 32'(frame_err2), 32'h1);
    checkOutput("stop2 parity_err", 32'(parity_err2), 32'h0);
    consume(1'b1);
    checkOutput("stop2 take valid", 32'(dout_valid2), 32'h0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, 2, 1'b1);
    checkOutput("stop2 clean dout", 32'(dout2), 32'hC3);
    checkOutput("stop2 clean frame_err", 32'(frame_err2), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
